// File: rtl/serdesphy_ana_pll_loop_ctrl.sv
// PFD-driven PI loop filter and VCO start-up sequencer for the SerDes PHY PLL.
// Optional control-word override port pair under `SERDESPHY_PLL_CTRL_OVERRIDE_EN.
module serdesphy_ana_pll_loop_ctrl #(
    parameter int UPDATE_DIV    = 16,
    parameter int INT_FRAC      = 4,
    parameter int KI            = 1,
    parameter int KP            = 4,
    parameter int LOCK_WIN      = 2,
    parameter int LOCK_CNT      = 32,
    parameter int READY_TIMEOUT = 1024
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       enable,
    input  logic       pfd_up,
    input  logic       pfd_dn,
    input  logic       vco_ready,
`ifdef SERDESPHY_PLL_CTRL_OVERRIDE_EN
    input  logic       ovr_en,
    input  logic [7:0] ovr_value,
`endif
    output logic       vco_enable,
    output logic [7:0] vco_control,
    output logic       pll_lock,
    output logic       pll_fault,
    output logic [2:0] loop_state
);

    localparam int IW   = 8 + INT_FRAC;
    localparam int EW   = $clog2(UPDATE_DIV) + 2;
    localparam int WW   = $clog2(UPDATE_DIV);
    localparam int LW   = $clog2(LOCK_CNT + 1);
    localparam int TW   = $clog2(READY_TIMEOUT + 1);
    localparam int IMAX = (1 << IW) - 1;

    localparam logic [IW-1:0] INTEG_RST = {8'd128, {INT_FRAC{1'b0}}};
    localparam logic [7:0]    CTRL_RST  = 8'd128;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_WAIT_RDY = 3'd1,
        ST_ACQUIRE  = 3'd2,
        ST_LOCKED   = 3'd3,
        ST_FAULT    = 3'd4
    } state_t;

    function automatic logic [IW-1:0] sat_integ(input logic signed [31:0] v);
        if (v < 0) return '0;
        if (v > IMAX) return '1;
        return v[IW-1:0];
    endfunction

    // Arithmetic shift floors toward -inf before clamping into the 8-bit code range.
    function automatic logic [7:0] sat_ctrl(input logic signed [31:0] v);
        logic signed [31:0] sh;
        sh = v >>> INT_FRAC;
        if (sh < 0) return 8'd0;
        if (sh > 255) return 8'd255;
        return sh[7:0];
    endfunction

    logic [2:0] sync_meta_q, sync_meta_d;
    logic [2:0] sync_q, sync_d;
    logic       up_s, dn_s, ready_s;

    state_t                state_q, state_d;
    logic [IW-1:0]         integ_q, integ_d;
    logic [7:0]            ctrl_q, ctrl_d;
    logic signed [EW-1:0]  err_q, err_d;
    logic [WW-1:0]         win_q, win_d;
    logic [LW-1:0]         lock_q, lock_d;
    logic [TW-1:0]         tmo_q, tmo_d;

    logic signed [EW-1:0]  err_step, err_acc;
    logic signed [31:0]    err_ext, integ_sum, ctrl_sum, ctrl_delta;
    logic [IW-1:0]         integ_new;
    logic [7:0]            ctrl_new;
    logic                  step_ok, win_last;
    logic [LW-1:0]         lock_inc;
    logic [TW-1:0]         tmo_inc;

    always_comb begin
        sync_meta_d = {vco_ready, pfd_dn, pfd_up};
        sync_d      = sync_meta_q;
    end

    assign up_s    = sync_q[0];
    assign dn_s    = sync_q[1];
    assign ready_s = sync_q[2];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_meta_q <= '0;
            sync_q      <= '0;
            state_q     <= ST_IDLE;
            integ_q     <= INTEG_RST;
            ctrl_q      <= CTRL_RST;
            err_q       <= '0;
            win_q       <= '0;
            lock_q      <= '0;
            tmo_q       <= '0;
        end else begin
            sync_meta_q <= sync_meta_d;
            sync_q      <= sync_d;
            state_q     <= state_d;
            integ_q     <= integ_d;
            ctrl_q      <= ctrl_d;
            err_q       <= err_d;
            win_q       <= win_d;
            lock_q      <= lock_d;
            tmo_q       <= tmo_d;
        end
    end

    // Window error includes the current cycle so the update sees all UPDATE_DIV samples.
    always_comb begin
        err_step = '0;
        if (up_s && !dn_s) begin
            err_step = {{(EW-1){1'b0}}, 1'b1};
        end else if (dn_s && !up_s) begin
            err_step = '1;
        end
        err_acc    = err_q + err_step;
        err_ext    = {{(32-EW){err_acc[EW-1]}}, err_acc};
        integ_sum  = $signed({{(32-IW){1'b0}}, integ_q}) + KI * err_ext;
        integ_new  = sat_integ(integ_sum);
        ctrl_sum   = $signed({{(32-IW){1'b0}}, integ_new}) + KP * err_ext;
        ctrl_new   = sat_ctrl(ctrl_sum);
        ctrl_delta = $signed({24'd0, ctrl_new}) - $signed({24'd0, ctrl_q});
        step_ok    = (ctrl_delta <= LOCK_WIN) && (ctrl_delta >= -LOCK_WIN);
        win_last   = (win_q == WW'(UPDATE_DIV - 1));
        lock_inc   = (lock_q == LW'(LOCK_CNT)) ? lock_q : lock_q + LW'(1);
        tmo_inc    = tmo_q + TW'(1);
    end

    always_comb begin
        state_d = state_q;
        integ_d = integ_q;
        ctrl_d  = ctrl_q;
        err_d   = err_q;
        win_d   = win_q;
        lock_d  = lock_q;
        tmo_d   = tmo_q;
        if (!enable) begin
            state_d = ST_IDLE;
            integ_d = INTEG_RST;
            ctrl_d  = CTRL_RST;
            err_d   = '0;
            win_d   = '0;
            lock_d  = '0;
            tmo_d   = '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    state_d = ST_WAIT_RDY;
                    tmo_d   = '0;
                end
                ST_WAIT_RDY: begin
                    err_d  = '0;
                    win_d  = '0;
                    lock_d = '0;
                    if (ready_s) begin
                        state_d = ST_ACQUIRE;
                        tmo_d   = '0;
                    end else begin
                        tmo_d = tmo_inc;
                        if (tmo_inc == TW'(READY_TIMEOUT)) state_d = ST_FAULT;
                    end
                end
                ST_ACQUIRE, ST_LOCKED: begin
                    // Losing ready wins over a coincident update: the loop word is frozen.
                    if (!ready_s) begin
                        state_d = ST_WAIT_RDY;
                        err_d   = '0;
                        win_d   = '0;
                        lock_d  = '0;
                        tmo_d   = '0;
                    end else if (win_last) begin
                        win_d   = '0;
                        err_d   = '0;
                        integ_d = integ_new;
                        ctrl_d  = ctrl_new;
                        if (step_ok) begin
                            lock_d = lock_inc;
                            if (lock_inc == LW'(LOCK_CNT)) state_d = ST_LOCKED;
                        end else begin
                            lock_d  = '0;
                            state_d = ST_ACQUIRE;
                        end
                    end else begin
                        win_d = win_q + WW'(1);
                        err_d = err_acc;
                    end
                end
                ST_FAULT: begin
                end
                default: state_d = ST_IDLE;
            endcase
        end
`ifdef SERDESPHY_PLL_CTRL_OVERRIDE_EN
        if (enable && ready_s && ovr_en &&
            (state_q == ST_ACQUIRE || state_q == ST_LOCKED)) begin
            state_d = ST_ACQUIRE;
            ctrl_d  = ovr_value;
            integ_d = {ovr_value, {INT_FRAC{1'b0}}};
            err_d   = '0;
            win_d   = '0;
            lock_d  = '0;
        end
`endif
    end

    assign loop_state  = state_q;
    assign vco_control = ctrl_q;
    assign vco_enable  = (state_q == ST_WAIT_RDY) || (state_q == ST_ACQUIRE) ||
                         (state_q == ST_LOCKED);
    assign pll_lock    = (state_q == ST_LOCKED);
    assign pll_fault   = (state_q == ST_FAULT);

endmodule
